// File: rtl/priority_encoder_8to3.sv
// Registered priority encoder: reports the index of the highest-numbered
// asserted request bit, plus an idle flag when no request is present.
// One-cycle latency, no combinational path from In to the outputs.
module priority_encoder_8to3 #(
  parameter int WIDTH = 8,
  parameter int OUT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] In,
  output logic             IDLE,
  output logic [OUT_W-1:0] Out
);

  // Highest set bit wins: later (higher) indices overwrite earlier ones.
  // An X/Z request bit tests false, so the registers always load a clean
  // value after the next sample.
  function automatic logic [OUT_W-1:0] encode_msb(input logic [WIDTH-1:0] req);
    logic [OUT_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (req[i] === 1'b1) begin
        idx = OUT_W'(i);
      end
    end
    return idx;
  endfunction

  // Idle only when every request bit is a clean zero.
  function automatic logic is_idle(input logic [WIDTH-1:0] req);
    logic any;
    any = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (req[i] === 1'b1) begin
        any = 1'b1;
      end
    end
    return ~any;
  endfunction

  // Stage p0: combinational encode of the sampled request vector.
  logic [OUT_W-1:0] out_p0;
  logic             idle_p0;

  // Encode the current request vector.
  always_comb begin
    out_p0  = encode_msb(In);
    idle_p0 = is_idle(In);
  end

  // Stage p1: output registers.
  logic [OUT_W-1:0] out_p1;
  logic             idle_p1;

  // Register the encoding; reset forces the idle encoding immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_p1  <= '0;
      idle_p1 <= 1'b1;
    end else begin
      out_p1  <= out_p0;
      idle_p1 <= idle_p0;
    end
  end

  assign Out  = out_p1;
  assign IDLE = idle_p1;

endmodule

// File: tb/tb_priority_encoder_8to3.sv
// Directed bench for priority_encoder_8to3 with hand-computed expectations.
module tb_priority_encoder_8to3;

  logic       clk;
  logic       clk_en;
  logic       rst_n;
  logic [7:0] in_vec;
  logic       idle;
  logic [2:0] out;

  int checks;
  int failures;

  priority_encoder_8to3 #(.WIDTH(8), .OUT_W(3)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .In   (in_vec),
    .IDLE (idle),
    .Out  (out)
  );

  always #5 if (clk_en) clk = ~clk;

  task automatic check(input string tag, input logic [2:0] exp_out, input logic exp_idle);
    checks++;
    assert ({out, idle} === {exp_out, exp_idle}) else begin
      failures++;
      $error("FAIL %s: observed Out=%0d IDLE=%0b expected Out=%0d IDLE=%0b",
             tag, out, idle, exp_out, exp_idle);
    end
  endtask

  // Drive on the falling edge, let one rising edge sample, check just after.
  task automatic step(input string tag, input logic [7:0] v,
                      input logic [2:0] exp_out, input logic exp_idle);
    @(negedge clk);
    in_vec = v;
    @(posedge clk);
    #1;
    check(tag, exp_out, exp_idle);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clk      = 1'b0;
    clk_en   = 1'b0;
    rst_n    = 1'b1;
    in_vec   = 8'hFF;

    // Reset asserted with no clock running.
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_immediate", 3'd0, 1'b1);
    #20;
    check("reset_held", 3'd0, 1'b1);

    // Start the clock while still in reset: outputs must not move.
    clk_en = 1'b1;
    @(posedge clk);
    #1;
    check("reset_clocked", 3'd0, 1'b1);
    @(negedge clk);
    in_vec = 8'h00;
    rst_n  = 1'b1;

    step("zero", 8'h00, 3'd0, 1'b1);

    // Walking one.
    step("walk0", 8'b0000_0001, 3'd0, 1'b0);
    step("walk1", 8'b0000_0010, 3'd1, 1'b0);
    step("walk2", 8'b0000_0100, 3'd2, 1'b0);
    step("walk3", 8'b0000_1000, 3'd3, 1'b0);
    step("walk4", 8'b0001_0000, 3'd4, 1'b0);
    step("walk5", 8'b0010_0000, 3'd5, 1'b0);
    step("walk6", 8'b0100_0000, 3'd6, 1'b0);
    step("walk7", 8'b1000_0000, 3'd7, 1'b0);

    // Multiple bits set.
    step("multi_81", 8'b1000_0001, 3'd7, 1'b0);
    step("multi_2c", 8'b0010_1100, 3'd5, 1'b0);
    step("multi_06", 8'b0000_0110, 3'd2, 1'b0);
    step("multi_7f", 8'b0111_1111, 3'd6, 1'b0);
    step("multi_ff", 8'hFF,        3'd7, 1'b0);
    step("multi_03", 8'b0000_0011, 3'd1, 1'b0);

    // Back-to-back on consecutive edges.
    step("b2b_00", 8'h00, 3'd0, 1'b1);
    step("b2b_01", 8'h01, 3'd0, 1'b0);
    step("b2b_80", 8'h80, 3'd7, 1'b0);
    step("b2b_00b", 8'h00, 3'd0, 1'b1);
    step("b2b_10", 8'h10, 3'd4, 1'b0);

    // Reset mid-operation between edges.
    step("pre_reset", 8'h80, 3'd7, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_async", 3'd0, 1'b1);
    in_vec = 8'h04;
    #2;
    rst_n = 1'b1;
    #1;
    check("midreset_release_hold", 3'd0, 1'b1);
    @(posedge clk);
    #1;
    check("post_reset_04", 3'd2, 1'b0);

    step("final_00", 8'h00, 3'd0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
